// File: rtl/ascon_perm_round_ctrl.sv
// rtl/ascon_perm_round_ctrl.sv - iterative ASCON permutation engine driving an external 64-lane S-box LUT
// Optional ASCON_SBOX_PIPE_EN: flop the LUT address, splitting substitution into SUB_A/SUB_D.
module ascon_perm_round_ctrl (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] state_o,
    output logic [319:0] sbox_addr_o,
    input  logic [319:0] sbox_data_i
);

`ifdef ASCON_SBOX_PIPE_EN
    typedef enum logic [2:0] {IDLE, SUB_A, SUB_D, LIN, DONE} fsm_t;
    localparam fsm_t FIRST_SUB = SUB_A;
`else
    typedef enum logic [1:0] {IDLE, SUB, LIN, DONE} fsm_t;
    localparam fsm_t FIRST_SUB = SUB;
`endif

    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [319:0] r_state;
    logic [3:0]   r_round;
    logic [7:0]   w_const;
    logic [319:0] w_state_c;
    logic [319:0] w_addr;
    logic [319:0] w_unsliced;
    logic [319:0] w_lin;
    logic [3:0]   w_rounds_sat;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Word k, bit i lands in lane i at position 4-k so that x0 is the lane MSB.
    function automatic logic [319:0] slice(input logic [319:0] s);
        logic [319:0] a;
        a = '0;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 5; k++)
                a[5*i + 4 - k] = s[64*k + i];
        return a;
    endfunction

    function automatic logic [319:0] unslice(input logic [319:0] a);
        logic [319:0] s;
        s = '0;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 5; k++)
                s[64*k + i] = a[5*i + 4 - k];
        return s;
    endfunction

    assign w_const      = {4'd15 - r_round, r_round};
    assign w_state_c    = r_state ^ {128'd0, 56'd0, w_const, 128'd0};
    assign w_addr       = slice(w_state_c);
    assign w_unsliced   = unslice(sbox_data_i);
    assign w_rounds_sat = (rounds_i == 4'd0 || rounds_i > 4'd12) ? 4'd12 : rounds_i;
    assign state_o      = r_state;

    always_comb begin
        w_lin[63:0]    = r_state[63:0]    ^ ror(r_state[63:0], 19)    ^ ror(r_state[63:0], 28);
        w_lin[127:64]  = r_state[127:64]  ^ ror(r_state[127:64], 61)  ^ ror(r_state[127:64], 39);
        w_lin[191:128] = r_state[191:128] ^ ror(r_state[191:128], 1)  ^ ror(r_state[191:128], 6);
        w_lin[255:192] = r_state[255:192] ^ ror(r_state[255:192], 10) ^ ror(r_state[255:192], 17);
        w_lin[319:256] = r_state[319:256] ^ ror(r_state[319:256], 7)  ^ ror(r_state[319:256], 41);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_fsm <= IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i)
                    w_fsm_nxt = FIRST_SUB;
            end
`ifdef ASCON_SBOX_PIPE_EN
            SUB_A:   w_fsm_nxt = SUB_D;
            SUB_D:   w_fsm_nxt = LIN;
`else
            SUB:     w_fsm_nxt = LIN;
`endif
            LIN:     w_fsm_nxt = (r_round == 4'd11) ? DONE : FIRST_SUB;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i)
                    w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid_i) begin
                    r_state <= state_i;
                    r_round <= 4'd12 - w_rounds_sat;
                end
`ifdef ASCON_SBOX_PIPE_EN
                SUB_D:   r_state <= w_unsliced;
`else
                SUB:     r_state <= w_unsliced;
`endif
                LIN: begin
                    r_state <= w_lin;
                    r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ASCON_SBOX_PIPE_EN
    logic [319:0] r_addr;

    // Reset value matches what the combinational path shows for a zero state at round 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_addr <= slice({128'd0, 56'd0, 8'hF0, 128'd0});
        else if (r_fsm == SUB_A)
            r_addr <= w_addr;
    end

    assign sbox_addr_o = r_addr;
`else
    assign sbox_addr_o = w_addr;
`endif

endmodule

// File: tb/tb_ascon_perm_round_ctrl.sv
// tb/tb_ascon_perm_round_ctrl.sv - randomized self-checking bench for ascon_perm_round_ctrl
module tb_ascon_perm_round_ctrl;

`ifdef ASCON_SBOX_PIPE_EN
    localparam int CPR = 3;
`else
    localparam int CPR = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [3:0]   rounds_i;
    logic [319:0] state_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [319:0] state_o;
    logic [319:0] sbox_addr_o;
    logic [319:0] sbox_data_i;

    bit           lut_id;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    ascon_perm_round_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .rounds_i    (rounds_i),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o),
        .sbox_addr_o (sbox_addr_o),
        .sbox_data_i (sbox_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // ASCON S-box in its bitsliced boolean form, applied across all 64 columns at once.
    function automatic logic [319:0] sbox_w(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x4, x3, x2, x1, x0} = s;
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [4:0] sbox5(input logic [4:0] v);
        logic [319:0] s, o;
        s = '0;
        for (int k = 0; k < 5; k++) s[64*k] = v[4-k];
        o = sbox_w(s);
        return {o[0], o[64], o[128], o[192], o[256]};
    endfunction

    function automatic int sat_rounds(input logic [3:0] rn);
        return (rn == 0 || rn > 12) ? 12 : int'(rn);
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input logic [3:0] rn, input bit ident);
        logic [63:0] x [5];
        logic [319:0] t;
        for (int k = 0; k < 5; k++) x[k] = s[64*k +: 64];
        for (int r = 12 - sat_rounds(rn); r < 12; r++) begin
            x[2] ^= 64'((15 - r) * 16 + r);
            if (!ident) begin
                t = sbox_w({x[4], x[3], x[2], x[1], x[0]});
                for (int k = 0; k < 5; k++) x[k] = t[64*k +: 64];
            end
            x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
            x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
            x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
            x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
            x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    always_comb begin
        sbox_data_i = '0;
        for (int i = 0; i < 64; i++)
            sbox_data_i[5*i +: 5] = lut_id ? sbox_addr_o[5*i +: 5] : sbox5(sbox_addr_o[5*i +: 5]);
    end

    task automatic chk(input logic [319:0] act, input logic [319:0] exp, input string name);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    bit           pend = 0;
    int           acc_cyc = 0;
    int           exp_lat = 0;
    logic [319:0] exp_st = '0;
    logic [319:0] rst_addr;

    always @(negedge clk) begin
        if (!rst_n_i) begin
            pend = 0;
            rst_addr = '0;
            for (int i = 4; i < 8; i++) rst_addr[5*i + 2] = 1'b1;
            chk(in_ready_o, 1, "rst_in_ready");
            chk(out_valid_o, 0, "rst_out_valid");
            chk(state_o, 0, "rst_state_o");
            chk(sbox_addr_o, rst_addr, "rst_sbox_addr");
        end else begin
            chk(in_ready_o, !pend, "in_ready");
            chk(out_valid_o, pend && (cyc >= acc_cyc + exp_lat), "out_valid");
            if (out_valid_o) chk(state_o, exp_st, "state_o");
            if (pend && out_valid_o && out_ready_i) begin
                pend = 0;
            end else if (!pend && in_valid_i && in_ready_o) begin
                pend    = 1;
                acc_cyc = cyc;
                exp_st  = perm(state_i, rounds_i, lut_id);
                exp_lat = CPR * sat_rounds(rounds_i) + 1;
            end
        end
    end

    task automatic send(input logic [319:0] s, input logic [3:0] rn, input bit keep);
        int n = 0;
        in_valid_i = 1'b1;
        state_i    = s;
        rounds_i   = rn;
        do begin @(negedge clk); n++; end while (!in_ready_o && n < 200);
        if (!in_ready_o) chk(in_ready_o, 1, "accept_timeout");
        @(posedge clk); #1;
        if (!keep) in_valid_i = 1'b0;
    endtask

    task automatic recv(input int hold, output int lat, output logic [319:0] st);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid_o && lat < 400);
        if (!out_valid_o) chk(out_valid_o, 1, "valid_timeout");
        st = state_o;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 out_ready_i = 1'b1;
        @(posedge clk); #1 out_ready_i = 1'b0;
    endtask

    logic [319:0] e_id, e_addr, st;
    logic [3:0]   rn;
    int           lat;

    initial begin
        rst_n_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        rounds_i = '0; state_i = '0; lut_id = 1'b1;

        e_id = '0;
        e_id[191:128] = 64'hAC0000000000006F;
        chk(sbox5(5'd0), 5'h04, "model_sbox_0");
        chk(sbox5(5'd1), 5'h0B, "model_sbox_1");
        chk(sbox5(5'd31), 5'h17, "model_sbox_31");
        chk(perm('0, 4'd1, 1'b1), e_id, "model_identity_r1");

        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;

        send('0, 4'd1, 1'b0);
        recv(0, lat, st);
        chk(lat, CPR + 1, "latency_r1");
        chk(st, e_id, "identity_zero_r1");

        e_addr = '0;
        for (int i = 0; i < 64; i++)
            e_addr[5*i +: 5] = (i == 0 || i == 1 || i == 3 || i == 6) ? 5'b10100 : 5'b10000;
        send({256'd0, {64{1'b1}}}, 4'd1, 1'b0);
        repeat (CPR - 1) @(negedge clk);
        chk(sbox_addr_o, e_addr, "sub_addr_lanes");
        recv(0, lat, st);

        lut_id = 1'b0;
        for (int t = 0; t < 8; t++) begin
            rn = (t == 0) ? 4'd12 : (t == 1) ? 4'd0 : (t == 2) ? 4'd8 : 4'($urandom_range(0, 15));
            send(rand320(), rn, 1'b0);
            recv($urandom_range(0, 2), lat, st);
            if (rn == 4'd12 || rn == 4'd0) chk(lat, 12 * CPR + 1, "latency_r12");
        end

        send(rand320(), 4'd1, 1'b1);
        recv(5, lat, st);
        @(negedge clk);
        chk(in_ready_o, 1, "reaccept_after_done");
        @(posedge clk); #1 in_valid_i = 1'b0;
        recv(0, lat, st);

        send(rand320(), 4'd12, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n_i = 1'b1;
        send(rand320(), 4'd12, 1'b0);
        recv(1, lat, st);
        chk(lat, 12 * CPR + 1, "latency_after_reset");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ascon_perm_round_ctrl.md
# ascon_perm_round_ctrl

Iterative ASCON permutation engine that drives the 64-lane S-box lookup table and consumes its results. It holds the 320-bit state, applies the round-constant addition, sends the 64 bit-sliced 5-bit columns to the LUT's address lanes, captures the substituted columns, and applies the linear diffusion layer. It runs the last `rounds` rounds of p12 per transaction. It sits between the AEAD/hash datapath (state in/out) and the S-box LUT (addr/data).

## Interface

- No parameters. Round count is a runtime input.
- `clk_i` input 1: clock.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `in_valid_i` input 1: request valid.
- `in_ready_o` output 1: engine idle and accepting.
- `rounds_i` input 4: number of rounds, sampled at accept. Valid range 1..12; 0 or >12 saturates to 12.
- `state_i` input 5x64: input state words x0..x4, index 0 = x0.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: consumer accepts result.
- `state_o` output 5x64: permuted state, stable while `out_valid_o` is high.
- `sbox_addr_o` output 64x5: lane i = {x0[i], x1[i], x2[i], x3[i], x4[i]}; x0 is the MSB.
- `sbox_data_i` input 64x5: LUT result, same bit order, combinational from `sbox_addr_o`.

## Operation

- FSM states: IDLE, SUB, LIN, DONE.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`: load `state_i` into the state register, load the round index r = 12 − rounds, go to SUB.
- Round constant: c = {4'(15−r), 4'(r)}, XORed into x2[7:0]. For r=11, c=0x4B; for r=0, c=0xF0.
- `sbox_addr_o` is driven at all times from the transposed (state XOR constant). It is meaningful only in SUB.
- SUB: capture `sbox_data_i` and un-transpose it into the state register (constant included), then go to LIN.
- LIN: apply the linear layer:
  - x0 ^= ror19 ^ ror28
  - x1 ^= ror61 ^ ror39
  - x2 ^= ror1 ^ ror6
  - x3 ^= ror10 ^ ror17
  - x4 ^= ror7 ^ ror41
- After LIN: increment r. If r was 11, go to DONE; otherwise go to SUB.
- DONE: `out_valid_o`=1 and `state_o` = state register. On `out_ready_i`, go to IDLE.
- `in_valid_i` is ignored outside IDLE. There is no abort input.
- The LUT's contents are not checked. An unprogrammed LUT yields its current contents.

## Timing

- Reset values: `in_ready_o`=1 (IDLE), `out_valid_o`=0, `state_o`=0, state register=0, r=0.
  - Because `sbox_addr_o` is derived from a zero state with r=0, it equals lane i = {0,0,c[i],0,0} with c=0xF0.
- Accept handshake: cycle 0.
  - First SUB in cycle 1.
  - Round k occupies cycles 2k−1 (SUB) and 2k (LIN).
  - `out_valid_o` rises in cycle 2R+1, giving a latency of 2R+1 cycles.
- Throughput: one transaction per 2R+2 cycles minimum. DONE→IDLE costs one cycle, so `in_ready_o` is never high while `out_valid_o` is high.
- Back-pressure: DONE holds indefinitely with `state_o` stable.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partial result is lost.

## Configuration

- `ASCON_SBOX_PIPE_EN` defined:
  - SUB splits into SUB_A and SUB_D.
  - SUB_A registers `sbox_addr_o`, so the output becomes flopped.
  - SUB_D captures `sbox_data_i`.
  - 3 cycles per round; latency 3R+1.
- Undefined: 2 cycles per round as described above, with `sbox_addr_o` combinational from the state register.

## Test plan

- Reset, then idle: `in_ready_o`=1, `out_valid_o`=0, `state_o`=0.
- LUT programmed as identity (data=addr), `rounds_i`=1, all-zero state:
  - `out_valid_o` high exactly 3 cycles after accept (4 with `ASCON_SBOX_PIPE_EN`).
  - Result x2=0xAC0000000000006F; all other words 0.
- Address check, `rounds_i`=1, x0=all ones, other words 0: in SUB, lanes 0,1,3,6 show 5'b10100; all other lanes show 5'b10000.
- ASCON S-box programmed, `rounds_i`=12 and `rounds_i`=0 on random states:
  - Both match the golden p12 model.
  - Latency 25 cycles (37 piped).
  - `rounds_i`=8 matches p8.
- Back-pressure: `out_ready_i` held low 5 cycles with `in_valid_i` high.
  - `state_o` stable, `in_ready_o`=0, no new accept.
  - Accept occurs one cycle after the DONE handshake.
- Reset pulsed in cycle 4 of a 12-round run:
  - Outputs return to reset values.
  - The next transaction produces the correct result.
